// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline front end.
package pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_ENC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWait
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: branch target, then jump target, then PC+4, else hold.
module next_pc_sel
  import pipeline_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              accept,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_pc4,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] jump_pc4,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;

  assign branch_target = branch_pc4 + branch_offset;
  assign jump_target   = {jump_pc4[31:28], jump_index, 2'b00};

  // The branch is the older instruction, so it wins over a same-cycle jump.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = target;
    end else if (accept) begin
      next_pc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch control: owns the PC, runs the imem req/ready handshake and
// the IF/ID latch, and applies branch/jump redirects.
module pc_fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchPC4,
  input  logic [ADDR_W-1:0]  BranchOffsetShifted,
  input  logic               Jump,
  input  logic [25:0]        JumpIndex,
  output logic               ImemReq,
  output logic [ADDR_W-1:0]  ImemAddr,
  input  logic               ImemReady,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] IfIdInstr,
  output logic [ADDR_W-1:0]  IfIdPC4,
  output logic               IfIdValid
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic               accept;
  logic               redirect;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  next_pc;

  // A pending redirect turns the in-flight response into a discard, never an accept.
  assign accept = ImemReady & ~Stall & ~redirect &
                  ((state_q == StFetch) | ((state_q == StWait) & ~pend_valid_q));

  next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .accept        (accept),
    .branch_taken  (BranchTaken),
    .branch_pc4    (BranchPC4),
    .branch_offset (BranchOffsetShifted),
    .jump          (Jump),
    .jump_index    (JumpIndex),
    .jump_pc4      (pc4_q),
    .redirect      (redirect),
    .target        (target),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        pc_d    = next_pc;
      end
      StFetch: begin
        pc_d = next_pc;
        if (!redirect && !Stall && !ImemReady) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (ImemReady) begin
          if (!redirect && pend_valid_q) begin
            pc_d = pend_pc_q;
          end else begin
            pc_d = next_pc;
          end
          if (redirect || pend_valid_q || !Stall) begin
            state_d      = StFetch;
            pend_valid_d = 1'b0;
          end
        end else if (redirect) begin
          // Address must stay stable until the stale request completes.
          pend_valid_d = 1'b1;
          pend_pc_d    = target;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      instr_d = ImemData;
      pc4_d   = pc_q + 32'd4;
      valid_d = 1'b1;
    end
    if (redirect) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign ImemReq   = (state_q != StIdle);
  assign ImemAddr  = pc_q;
  assign IfIdInstr = instr_q;
  assign IfIdPC4   = pc4_q;
  assign IfIdValid = valid_q;

endmodule
